// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the CPU run controller
// Holds the controller state enum and the strobe counter width used by cpu_run_ctrl.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HALT,
        S_RUN,
        S_STEP,
        S_BREAK
    } ctrl_state_t;

    localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - button synchronizer and rising-edge pulse generator
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   in     asynchronous button level
//   pulse  one-cycle registered pulse per rising edge of in
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // The pulse is registered so a level first sampled at edge k shows up
    // as a pulse in the cycle after edge k+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step/breakpoint sequencer for the 4-bit CPU
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   run_btn          button level, rising edge requests RUN
//   step_btn         button level, rising edge requests one instruction
//   halt_btn         button level, rising edge requests HALT
//   bp_en, bp_addr   PC-match breakpoint enable and address
//   pc               current CPU program counter
//   cpu_en           one-cycle CPU advance strobe
//   running          state is RUN
//   at_break         state is BREAK
//   step_count       strobes issued, modulo 256
import cpu_ctrl_pkg::*;

module cpu_run_ctrl #(
    parameter int PRESCALE = 1000,
    parameter int CNT_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_btn,
    input  logic                  step_btn,
    input  logic                  halt_btn,
    input  logic                  bp_en,
    input  logic [3:0]            bp_addr,
    input  logic [3:0]            pc,
    output logic                  cpu_en,
    output logic                  running,
    output logic                  at_break,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    ctrl_state_t    state;
    ctrl_state_t    state_next;
    logic [CNT_W-1:0] cnt;
    logic           skip_bp;
    logic           run_p;
    logic           step_p;
    logic           halt_p;
    logic           slot;
    logic           bp_hit;
    logic           strobe;
    logic           run_enter;

    btn_edge u_run_edge  (.clk(clk), .rst(rst), .in(run_btn),  .pulse(run_p));
    btn_edge u_step_edge (.clk(clk), .rst(rst), .in(step_btn), .pulse(step_p));
    btn_edge u_halt_edge (.clk(clk), .rst(rst), .in(halt_btn), .pulse(halt_p));

    assign slot   = (cnt == CNT_LAST);
    // skip_bp lets the instruction we stopped on execute once after resuming.
    assign bp_hit = bp_en && (pc == bp_addr) && !skip_bp;

    always_comb begin
        state_next = state;
        strobe     = 1'b0;
        run_enter  = 1'b0;
        case (state)
            S_HALT, S_BREAK: begin
                if (halt_p) begin
                    state_next = S_HALT;
                end else if (run_p) begin
                    state_next = S_RUN;
                    run_enter  = 1'b1;
                end else if (step_p) begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                strobe     = 1'b1;
                state_next = S_HALT;
            end
            S_RUN: begin
                if (halt_p) begin
                    state_next = S_HALT;
                end else if (slot) begin
                    if (bp_hit) begin
                        state_next = S_BREAK;
                    end else begin
                        strobe = 1'b1;
                    end
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    assign cpu_en   = strobe & ~rst;
    assign running  = (state == S_RUN);
    assign at_break = (state == S_BREAK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HALT;
            cnt        <= '0;
            skip_bp    <= 1'b0;
            step_count <= '0;
        end else begin
            state <= state_next;
            if (run_enter) begin
                cnt     <= '0;
                skip_bp <= 1'b1;
            end else if (state == S_RUN) begin
                cnt <= slot ? '0 : cnt + CNT_W'(1);
                if (strobe) begin
                    skip_bp <= 1'b0;
                end
            end
            if (strobe) begin
                step_count <= step_count + STEP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    localparam int P = 4;
    localparam int B_RUN  = 1;
    localparam int B_STEP = 2;
    localparam int B_HALT = 4;
    localparam int M_HALT  = 10;
    localparam int M_RUN   = 11;
    localparam int M_STEP  = 12;
    localparam int M_BREAK = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_btn = 1'b0;
    logic       step_btn = 1'b0;
    logic       halt_btn = 1'b0;
    logic       bp_en = 1'b0;
    logic [3:0] bp_addr = 4'd0;
    logic [3:0] pc = 4'd0;
    logic       cpu_en;
    logic       running;
    logic       at_break;
    logic [7:0] step_count;
    logic       pc_load = 1'b0;
    logic [3:0] pc_load_val = 4'd0;

    int total = 0;
    int bad = 0;
    int en_seen = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.PRESCALE(P), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .run_btn(run_btn), .step_btn(step_btn), .halt_btn(halt_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(cpu_en), .running(running), .at_break(at_break),
        .step_count(step_count)
    );

    // Stand-in for the CPU: PC advances on every strobe.
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (cpu_en) pc <= pc + 4'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: button i is seen as a press once it was sampled high
    // two edges ago and low three edges ago; the mode advances by the rules.
    bit h_run[4];
    bit h_step[4];
    bit h_halt[4];
    int m_mode = M_HALT;
    int m_age = 0;
    bit m_skip = 0;
    int m_count = 0;
    bit m_valid = 0;

    always @(negedge clk) begin
        bit rp, sp, hp, exp_en, at_slot, hit;
        int nxt;
        rp = h_run[2] & ~h_run[3];
        sp = h_step[2] & ~h_step[3];
        hp = h_halt[2] & ~h_halt[3];
        nxt = m_mode;
        exp_en = 0;
        at_slot = ((m_age % P) == P - 1);
        hit = bp_en && (pc == bp_addr) && !m_skip;
        if (m_mode == M_STEP) begin
            exp_en = 1;
            nxt = M_HALT;
        end else if (m_mode == M_RUN) begin
            if (hp) nxt = M_HALT;
            else if (at_slot && hit) nxt = M_BREAK;
            else if (at_slot) exp_en = 1;
        end else begin
            if (hp) nxt = M_HALT;
            else if (rp) nxt = M_RUN;
            else if (sp) nxt = M_STEP;
        end
        if (rst) exp_en = 0;
        if (m_valid) begin
            chk("cpu_en", int'(cpu_en), int'(exp_en));
            chk("running", int'(running), int'(m_mode == M_RUN));
            chk("at_break", int'(at_break), int'(m_mode == M_BREAK));
            chk("step_count", int'(step_count), m_count);
        end
        if (cpu_en) en_seen++;
        if (rst) begin
            m_mode = M_HALT; m_age = 0; m_skip = 0; m_count = 0; m_valid = 1;
            for (int i = 0; i < 4; i++) begin
                h_run[i] = 0; h_step[i] = 0; h_halt[i] = 0;
            end
        end else begin
            if (m_mode != M_RUN && nxt == M_RUN) begin
                m_age = 0;
                m_skip = 1;
            end else if (m_mode == M_RUN) begin
                m_age++;
                if (exp_en) m_skip = 0;
            end
            if (exp_en) m_count = (m_count + 1) % 256;
            m_mode = nxt;
            for (int i = 3; i > 0; i--) begin
                h_run[i] = h_run[i-1]; h_step[i] = h_step[i-1]; h_halt[i] = h_halt[i-1];
            end
            h_run[0] = run_btn; h_step[0] = step_btn; h_halt[0] = halt_btn;
        end
    end

    task automatic press(input int mask);
        @(posedge clk); #2;
        if (mask & B_RUN)  run_btn = 1'b1;
        if (mask & B_STEP) step_btn = 1'b1;
        if (mask & B_HALT) halt_btn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        int first, second, snap, got, found, r;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_cpu_en", int'(cpu_en), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_at_break", int'(at_break), 0);
        chk("reset_step_count", int'(step_count), 0);

        snap = en_seen;
        repeat (50) @(posedge clk);
        #1;
        chk("idle_strobes", en_seen - snap, 0);
        chk("idle_step_count", int'(step_count), 0);
        chk("idle_running", int'(running), 0);

        // single step: strobe 4 negedges after the level is driven
        @(posedge clk); #2 step_btn = 1'b1;
        snap = en_seen;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_en && first < 0) first = i;
        end
        step_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("step_latency", first, 4);
        chk("step_strobes", en_seen - snap, 1);
        chk("step_count_one", int'(step_count), 1);
        chk("step_back_halt", int'(running | at_break), 0);

        // free run: first strobe at the fourth RUN cycle, then every P
        @(posedge clk); #2 run_btn = 1'b1;
        first = -1; second = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (cpu_en) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        run_btn = 1'b0;
        chk("run_first_strobe", first, 7);
        chk("run_second_strobe", second, 11);
        repeat (24) @(posedge clk);
        #1 chk("run_running", int'(running), 1);
        press(B_HALT);
        repeat (6) @(posedge clk);
        #1 chk("halt_running", int'(running), 0);
        snap = en_seen;
        repeat (20) @(posedge clk);
        #1 chk("halt_no_strobes", en_seen - snap, 0);

        // breakpoint at pc 5
        do_reset();
        pc_load_val = 4'd0; pc_load = 1'b1;
        @(posedge clk); #2 pc_load = 1'b0;
        bp_en = 1'b1; bp_addr = 4'd5;
        press(B_RUN);
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            @(negedge clk);
            if (at_break) found = 1;
        end
        chk("bp_reached", found, 1);
        chk("bp_step_count", int'(step_count), 5);
        chk("bp_pc", int'(pc), 5);
        chk("bp_not_running", int'(running), 0);
        press(B_RUN);
        got = -1;
        for (int i = 0; i < 20 && got < 0; i++) begin
            @(negedge clk);
            if (cpu_en) got = int'(pc);
        end
        chk("bp_resume_pc", got, 5);
        repeat (20) @(posedge clk);
        #1 chk("bp_resume_running", int'(running), 1);
        press(B_HALT);
        bp_en = 1'b0;
        repeat (8) @(posedge clk);

        // coincident requests
        snap = en_seen;
        press(B_RUN | B_HALT);
        repeat (10) @(negedge clk);
        chk("run_halt_running", int'(running), 0);
        chk("run_halt_strobes", en_seen - snap, 0);
        press(B_RUN | B_STEP);
        repeat (8) @(negedge clk);
        chk("run_step_running", int'(running), 1);
        press(B_HALT);
        repeat (8) @(posedge clk);

        // 300 steps wrap to 44
        do_reset();
        for (int n = 0; n < 300; n++) begin
            press(B_STEP);
            repeat (4) @(posedge clk);
        end
        repeat (10) @(posedge clk);
        #1 chk("wrap_step_count", int'(step_count), 44);

        // reset in a RUN slot
        press(B_RUN);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (cpu_en) found = 1;
        end
        chk("rst_run_strobe_seen", found, 1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_cpu_en_low", int'(cpu_en), 0);
        @(posedge clk);
        #1;
        chk("rst_step_count", int'(step_count), 0);
        chk("rst_running", int'(running), 0);
        #1 rst = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            pc_load = 1'b0;
            rst = 1'b0;
            r = int'($urandom_range(0, 999));
            if (r < 40) run_btn = ~run_btn;
            else if (r < 80) step_btn = ~step_btn;
            else if (r < 95) halt_btn = ~halt_btn;
            else if (r < 110) bp_en = ~bp_en;
            else if (r < 125) bp_addr = 4'($urandom_range(0, 15));
            else if (r < 135) begin
                pc_load_val = 4'($urandom_range(0, 15));
                pc_load = 1'b1;
            end else if (r < 139) rst = 1'b1;
        end
        @(posedge clk); #2;
        rst = 1'b0; pc_load = 1'b0;
        run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
